seq_logic_unit: RTL



---
 rtl/seq_logic_pkg.sv | 20 ++
 rtl/seq_logic_unit_logic_slice.sv | 25 ++
 rtl/seq_logic_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/seq_logic_pkg.sv
// Shared types and defaults for the slice-serial logic unit.
package seq_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

endpackage

// File: rtl/seq_logic_unit_logic_slice.sv
// One SLICE-wide bitwise gate array, reused every cycle by the top.
module logic_slice
  import seq_logic_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  op_t              op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  // Select the requested bitwise function.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Slice-serial bitwise logic unit (AND/OR/XOR/NOR), LSB slice first.
// Optional parity output enabled by defining SEQ_LOGIC_UNIT_PARITY_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start
//   RUN     | evaluating slice k each cycle, k = 0..N-1
//   DONE    | result/zero just loaded; start here begins the next operation
module seq_logic_unit
  import seq_logic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t            state, state_nxt;
  logic [KW-1:0]     k;
  op_t               op_q;
  logic [WIDTH-1:0]  a_q, b_q, acc, acc_nxt;
  logic [SLICE-1:0]  a_s, b_s, y_s;
  logic              last, launch;

  assign last   = (k == KW'(N - 1));
  // start is only honoured outside RUN
  assign launch = start && (state != ST_RUN);
  assign a_s    = a_q[int'(k)*SLICE +: SLICE];
  assign b_s    = b_q[int'(k)*SLICE +: SLICE];

  logic_slice #(.SLICE(SLICE)) u_slice (
    .op (op_q),
    .a  (a_s),
    .b  (b_s),
    .y  (y_s)
  );

  // Accumulator with the current slice merged in.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(k)*SLICE +: SLICE] = y_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded straight from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Operand capture, slice counter, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_AND;
      a_q    <= '0;
      b_q    <= '0;
      k      <= '0;
      acc    <= '0;
      result <= '0;
      zero   <= 1'b0;
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (launch) begin
      op_q <= op_t'(op);
      a_q  <= input1;
      b_q  <= input2;
      k    <= '0;
    end else if (state == ST_RUN) begin
      acc <= acc_nxt;
      if (last) begin
        result <= acc_nxt;
        zero   <= (acc_nxt == '0);
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
        parity <= ^acc_nxt;
`endif
      end else begin
        k <= k + KW'(1);
      end
    end
  end

endmodule
